// File: rtl/clock_set_ctrl.sv
// Run/set sequencing controller for the desk clock's seconds, minutes and hours counters.
// Optional inactivity timeout in set mode is enabled by defining CLOCK_SET_TIMEOUT_EN.
module clock_set_ctrl #(
    parameter int REPEAT_DLY = 4,
    parameter int TIMEOUT_S  = 10
) (
    input  logic       i_sysclk,
    input  logic       i_reset_n,
    input  logic       i_1hz_stb,
    input  logic       i_fast_stb,
    input  logic       i_set_btn,
    input  logic       i_up_btn,
    input  logic       i_sec_max,
    input  logic       i_min_max,
    input  logic       i_hr_max,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hr_en,
    output logic       o_sec_clr,
    output logic       o_min_clr,
    output logic       o_hr_clr,
    output logic [1:0] o_mode,
    output logic       o_blink
);

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_SET_HR  = 2'b01,
        MODE_SET_MIN = 2'b10
    } mode_t;

    localparam logic [3:0] HOLD_MAX = 4'(REPEAT_DLY);

    mode_t      mode_q, mode_d;
    logic       set_btn_q, set_btn_d;
    logic       up_btn_q, up_btn_d;
    logic [3:0] hold_q, hold_d;
    logic       blink_q, blink_d;
    logic       sec_en_q, sec_en_d, sec_clr_q, sec_clr_d;
    logic       min_en_q, min_en_d, min_clr_q, min_clr_d;
    logic       hr_en_q, hr_en_d, hr_clr_q, hr_clr_d;

`ifdef CLOCK_SET_TIMEOUT_EN
    localparam logic [5:0] IDLE_LAST = 6'(TIMEOUT_S - 1);
    logic [5:0] idle_q, idle_d;
`endif

    logic set_press, up_press, rep_inc, field_inc;

    assign set_press = i_set_btn & ~set_btn_q;
    assign up_press  = i_up_btn & ~up_btn_q;

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        mode_d    = mode_q;
        set_btn_d = i_set_btn;
        up_btn_d  = i_up_btn;
        hold_d    = hold_q;
        blink_d   = blink_q;
        sec_en_d  = 1'b0;
        sec_clr_d = 1'b0;
        min_en_d  = 1'b0;
        min_clr_d = 1'b0;
        hr_en_d   = 1'b0;
        hr_clr_d  = 1'b0;
        rep_inc   = 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
        idle_d    = idle_q;
`endif

        // Hold counter saturates at HOLD_MAX; strobes beyond that are repeat increments.
        if (up_press || !i_up_btn) begin
            hold_d = 4'd0;
        end else if (i_fast_stb) begin
            if (hold_q == HOLD_MAX) rep_inc = 1'b1;
            else                    hold_d  = hold_q + 4'd1;
        end

        // A SET press in the same cycle swallows any UP increment.
        field_inc = (up_press | rep_inc) & ~set_press;

        case (mode_q)
            MODE_RUN: begin
                if (i_1hz_stb) begin
                    sec_clr_d = i_sec_max;
                    sec_en_d  = ~i_sec_max;
                    min_clr_d = i_sec_max & i_min_max;
                    min_en_d  = i_sec_max & ~i_min_max;
                    hr_clr_d  = i_sec_max & i_min_max & i_hr_max;
                    hr_en_d   = i_sec_max & i_min_max & ~i_hr_max;
                end
                if (set_press) mode_d = MODE_SET_HR;
            end
            MODE_SET_HR: begin
                hr_clr_d = field_inc & i_hr_max;
                hr_en_d  = field_inc & ~i_hr_max;
                if (set_press) mode_d = MODE_SET_MIN;
            end
            MODE_SET_MIN: begin
                min_clr_d = field_inc & i_min_max;
                min_en_d  = field_inc & ~i_min_max;
                if (set_press) begin
                    mode_d    = MODE_RUN;
                    sec_clr_d = 1'b1;
                end
            end
            default: mode_d = MODE_RUN;
        endcase

`ifdef CLOCK_SET_TIMEOUT_EN
        if (mode_q == MODE_RUN || set_press || up_press) begin
            idle_d = 6'd0;
        end else if (i_1hz_stb) begin
            if (idle_q == IDLE_LAST) begin
                idle_d    = 6'd0;
                mode_d    = MODE_RUN;
                sec_clr_d = 1'b1;
            end else begin
                idle_d = idle_q + 6'd1;
            end
        end
`endif

        if (mode_d != mode_q || mode_q == MODE_RUN) blink_d = 1'b0;
        else if (i_fast_stb)                        blink_d = ~blink_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mode_q    <= MODE_RUN;
            set_btn_q <= 1'b0;
            up_btn_q  <= 1'b0;
            hold_q    <= 4'd0;
            blink_q   <= 1'b0;
            sec_en_q  <= 1'b0;
            sec_clr_q <= 1'b0;
            min_en_q  <= 1'b0;
            min_clr_q <= 1'b0;
            hr_en_q   <= 1'b0;
            hr_clr_q  <= 1'b0;
`ifdef CLOCK_SET_TIMEOUT_EN
            idle_q    <= 6'd0;
`endif
        end else begin
            mode_q    <= mode_d;
            set_btn_q <= set_btn_d;
            up_btn_q  <= up_btn_d;
            hold_q    <= hold_d;
            blink_q   <= blink_d;
            sec_en_q  <= sec_en_d;
            sec_clr_q <= sec_clr_d;
            min_en_q  <= min_en_d;
            min_clr_q <= min_clr_d;
            hr_en_q   <= hr_en_d;
            hr_clr_q  <= hr_clr_d;
`ifdef CLOCK_SET_TIMEOUT_EN
            idle_q    <= idle_d;
`endif
        end
    end

    assign o_mode    = mode_q;
    assign o_blink   = blink_q;
    assign o_sec_en  = sec_en_q;
    assign o_sec_clr = sec_clr_q;
    assign o_min_en  = min_en_q;
    assign o_min_clr = min_clr_q;
    assign o_hr_en   = hr_en_q;
    assign o_hr_clr  = hr_clr_q;

endmodule
